// File: rtl/sm_multi_counter.sv
// sm_multi_counter: NUM_CH independent up/down counters with load,
// terminal compare and sticky flags; SM_MULTI_COUNTER_PRESCALE_EN adds a tick.
module sm_multi_counter #(
  parameter int WIDTH  = 5,
  parameter int NUM_CH = 4,
  parameter int WRAP   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       act,
  input  logic [NUM_CH-1:0]       up_dwn_n,
  input  logic [NUM_CH-1:0]       load,
  input  logic [WIDTH-1:0]        load_val,
  input  logic [WIDTH-1:0]        term_val,
  input  logic [NUM_CH-1:0]       flag_clr,
`ifdef SM_MULTI_COUNTER_PRESCALE_EN
  input  logic [7:0]              prescale,
`endif
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       ovflw,
  output logic [NUM_CH-1:0]       unflw,
  output logic [NUM_CH-1:0]       term_hit
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic tick;

`ifdef SM_MULTI_COUNTER_PRESCALE_EN
  logic [7:0] pre_q;
  logic [7:0] pre_d;

  // free-running divider; >= keeps it sane if prescale shrinks mid-run
  always_comb begin
    tick  = (pre_q >= prescale);
    pre_d = tick ? 8'd0 : pre_q + 8'd1;
  end

  // prescale counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= 8'd0;
    else        pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           st_q;
    state_t           st_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             hit_q;
    logic             hit_d;
    logic             do_step;

    // next-state, count, flags and terminal pulse for this channel
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q & ~flag_clr[g];
      unf_d   = unf_q & ~flag_clr[g];
      hit_d   = 1'b0;
      do_step = 1'b0;

      unique case (st_q)
        S_IDLE: begin
          if (act[g]) begin
            st_d    = S_COUNT;
            do_step = tick;
          end
        end
        S_COUNT: begin
          if (!act[g]) st_d = S_IDLE;
          else         do_step = tick;
        end
        S_HALT: begin
          if (flag_clr[g]) st_d = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase

      if (do_step) begin
        if (up_dwn_n[g]) begin
          if (cnt_q == MAX) begin
            ovf_d = 1'b1;
            if (WRAP != 0) cnt_d = '0;
            else           st_d  = S_HALT;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          if (cnt_q == '0) begin
            unf_d = 1'b1;
            if (WRAP != 0) cnt_d = MAX;
            else           st_d  = S_HALT;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        // a saturating step leaves the count unchanged: no pulse
        hit_d = (cnt_d != cnt_q) && (cnt_d == term_val);
      end

      if (load[g]) begin
        st_d  = S_IDLE;
        cnt_d = load_val;
        ovf_d = ovf_q & ~flag_clr[g];
        unf_d = unf_q & ~flag_clr[g];
        hit_d = (load_val == term_val);
      end
    end

    // channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= S_IDLE;
        cnt_q <= '0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        hit_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        hit_q <= hit_d;
      end
    end

    assign count[g*WIDTH +: WIDTH] = cnt_q;
    assign ovflw[g]    = ovf_q;
    assign unflw[g]    = unf_q;
    assign term_hit[g] = hit_q;
  end

endmodule
